// File: rtl/seq_controller_if.sv
// Handshake bundle between the SEQ stage sequencer and the Y86-64 datapath.
// The sequencer uses the master view; the datapath (or a bench) uses the slave view.
interface seq_controller_if;
  logic        start;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        instr_valid;
  logic        imem_error;
  logic        Condition;
  logic        dmem_ready;
  logic        dmem_error;

  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        mem_en;
  logic        wb_en;
  logic        pc_en;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [1:0]  stat;
  logic        busy;
  logic [31:0] instr_count;

  modport master (
    input  start, icode, rA, rB, instr_valid, imem_error,
           Condition, dmem_ready, dmem_error,
    output fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en,
           mem_read, mem_write, srcA, srcB, dstE, dstM,
           stat, busy, instr_count
  );

  modport slave (
    output start, icode, rA, rB, instr_valid, imem_error,
           Condition, dmem_ready, dmem_error,
    input  fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en,
           mem_read, mem_write, srcA, srcB, dstE, dstM,
           stat, busy, instr_count
  );
endinterface

// File: rtl/seq_controller.sv
// Multi-cycle stage sequencer for the SEQ Y86-64 core: one stage strobe per cycle,
// register-ID generation from the latched instruction, and status/halt tracking.
module seq_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PCUPD     = 3'd6,
    ST_HALT      = 3'd7
  } state_e;

  localparam int TW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  function automatic logic is_mem_read(input logic [3:0] ic);
    return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
  endfunction

  function automatic logic [3:0] src_a_of(input logic [3:0] ic, input logic [3:0] ra);
    logic [3:0] r;
    case (ic)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: r = ra;
      I_RET, I_POPQ:                      r = R_RSP;
      default:                            r = R_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] src_b_of(input logic [3:0] ic, input logic [3:0] rb);
    logic [3:0] r;
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:       r = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:  r = R_RSP;
      default:                         r = R_NONE;
    endcase
    return r;
  endfunction

  // cmovXX only writes its destination when the condition held in EXECUTE.
  function automatic logic [3:0] dst_e_of(input logic [3:0] ic, input logic [3:0] rb,
                                          input logic cnd);
    logic [3:0] r;
    case (ic)
      I_RRMOVQ:                        r = cnd ? rb : R_NONE;
      I_IRMOVQ, I_OPQ:                 r = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:  r = R_RSP;
      default:                         r = R_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] dst_m_of(input logic [3:0] ic, input logic [3:0] ra);
    logic [3:0] r;
    case (ic)
      I_MRMOVQ, I_POPQ: r = ra;
      default:          r = R_NONE;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    icode_q, icode_d;
  logic [3:0]    ra_q, ra_d;
  logic [3:0]    rb_q, rb_d;
  logic          cnd_q, cnd_d;
  logic [1:0]    stat_q, stat_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          id_active_s;

  // State and datapath-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      icode_q <= 4'h0;
      ra_q    <= R_NONE;
      rb_q    <= R_NONE;
      cnd_q   <= 1'b0;
      stat_q  <= STAT_AOK;
      cnt_q   <= 32'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      icode_q <= icode_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      cnd_q   <= cnd_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic; status is updated on the same edge that enters HALT.
  always_comb begin
    state_d = state_q;
    icode_d = icode_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    cnd_d   = cnd_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        icode_d = bus.icode;
        ra_d    = bus.rA;
        rb_d    = bus.rB;
        if (bus.imem_error) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALT;
        end else if (!bus.instr_valid) begin
          stat_d  = STAT_INS;
          state_d = ST_HALT;
        end else begin
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        cnd_d = bus.Condition;
        if (is_mem_read(icode_q) || is_mem_write(icode_q)) begin
          tmo_d   = '0;
          state_d = ST_MEMORY;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end

      // The faulting access never retires, so the count is left untouched.
      ST_MEMORY: begin
        if (bus.dmem_ready) begin
          if (bus.dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = ST_HALT;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (tmo_q == TMO_LAST) begin
          stat_d  = STAT_ADR;
          state_d = ST_HALT;
        end else begin
          tmo_d   = tmo_q + TW'(1);
          state_d = ST_MEMORY;
        end
      end

      ST_WRITEBACK: begin
        state_d = ST_PCUPD;
      end

      ST_PCUPD: begin
        cnt_d = cnt_q + 32'd1;
        if (icode_q == I_HALT) begin
          stat_d  = STAT_HLT;
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  assign id_active_s = (state_q == ST_DECODE)    || (state_q == ST_EXECUTE) ||
                       (state_q == ST_MEMORY)    || (state_q == ST_WRITEBACK) ||
                       (state_q == ST_PCUPD);

  // Moore decodes of the state register and latched instruction fields.
  always_comb begin
    bus.fetch_en    = (state_q == ST_FETCH);
    bus.decode_en   = (state_q == ST_DECODE);
    bus.execute_en  = (state_q == ST_EXECUTE);
    bus.mem_en      = (state_q == ST_MEMORY);
    bus.wb_en       = (state_q == ST_WRITEBACK);
    bus.pc_en       = (state_q == ST_PCUPD);
    bus.busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    bus.stat        = stat_q;
    bus.instr_count = cnt_q;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.srcA        = R_NONE;
    bus.srcB        = R_NONE;
    bus.dstE        = R_NONE;
    bus.dstM        = R_NONE;

    if (state_q == ST_MEMORY) begin
      bus.mem_read  = is_mem_read(icode_q);
      bus.mem_write = is_mem_write(icode_q);
    end else begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end

    if (id_active_s) begin
      bus.srcA = src_a_of(icode_q, ra_q);
      bus.srcB = src_b_of(icode_q, rb_q);
      bus.dstE = dst_e_of(icode_q, rb_q, cnd_q);
      bus.dstM = dst_m_of(icode_q, ra_q);
    end else begin
      bus.srcA = R_NONE;
      bus.srcB = R_NONE;
      bus.dstE = R_NONE;
      bus.dstM = R_NONE;
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: a per-cycle vector table for a short program,
// then hand-written sequences for halt, faults, timeout and asynchronous reset.
module tb_seq_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seq_controller_if bus();

  seq_controller #(.MEM_TIMEOUT(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SF = 6'b100000;
  localparam logic [5:0] SD = 6'b010000;
  localparam logic [5:0] SE = 6'b001000;
  localparam logic [5:0] SM = 6'b000100;
  localparam logic [5:0] SW = 6'b000010;
  localparam logic [5:0] SP = 6'b000001;
  localparam logic [3:0] NO = 4'hF;

  typedef struct {
    logic        start;
    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        cond;
    logic        rdy;
    logic [5:0]  strb;
    logic [1:0]  rw;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [3:0]  de;
    logic [3:0]  dm;
    logic        bz;
    logic [31:0] cnt;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t v[26];

  function automatic vec_t mk(input logic st, input logic [3:0] ic, input logic [3:0] ra,
                              input logic [3:0] rb, input logic cd, input logic rdy,
                              input logic [5:0] sbv, input logic [1:0] rw,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] e, input logic [3:0] m,
                              input logic bz, input logic [31:0] cnt);
    vec_t r;
    r.start = st;  r.icode = ic; r.ra = ra; r.rb = rb; r.cond = cd; r.rdy = rdy;
    r.strb  = sbv; r.rw = rw; r.sa = a; r.sb = b; r.de = e; r.dm = m;
    r.bz    = bz;  r.cnt = cnt;
    return r;
  endfunction

  function automatic logic [5:0] strobes();
    return {bus.fetch_en, bus.decode_en, bus.execute_en, bus.mem_en, bus.wb_en, bus.pc_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.icode       = 4'h0;
    bus.rA          = 4'h0;
    bus.rB          = 4'h0;
    bus.instr_valid = 1'b1;
    bus.imem_error  = 1'b0;
    bus.Condition   = 1'b0;
    bus.dmem_ready  = 1'b0;
    bus.dmem_error  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " strobes"}, 32'(strobes()), 32'(S0));
    chk({tag, " rw"}, 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk({tag, " ids"}, 32'({bus.srcA, bus.srcB, bus.dstE, bus.dstM}), 32'hFFFF);
    chk({tag, " stat"}, 32'(bus.stat), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " count"}, bus.instr_count, 32'd0);
  endtask

  // Start the machine and leave it in DECODE with the given instruction latched.
  task automatic start_instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.icode = ic;
    bus.rA    = ra;
    bus.rB    = rb;
    cyc();
  endtask

  initial begin
    // addq, cmovle (not taken), cmovle (taken), popq with 3 wait cycles, then next fetch
    v[0]  = mk(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, S0, 2'b00, NO,   NO,   NO,   NO,   1'b0, 32'd0);
    v[1]  = mk(1'b0, 4'h6, 4'hB, 4'h0, 1'b0, 1'b0, SF, 2'b00, NO,   NO,   NO,   NO,   1'b1, 32'd0);
    v[2]  = mk(1'b0, 4'h6, 4'hB, 4'h0, 1'b0, 1'b0, SD, 2'b00, 4'hB, 4'h0, 4'h0, NO,   1'b1, 32'd0);
    v[3]  = mk(1'b0, 4'h6, 4'hB, 4'h0, 1'b0, 1'b0, SE, 2'b00, 4'hB, 4'h0, 4'h0, NO,   1'b1, 32'd0);
    v[4]  = mk(1'b0, 4'h6, 4'hB, 4'h0, 1'b0, 1'b0, SW, 2'b00, 4'hB, 4'h0, 4'h0, NO,   1'b1, 32'd0);
    v[5]  = mk(1'b0, 4'h6, 4'hB, 4'h0, 1'b0, 1'b0, SP, 2'b00, 4'hB, 4'h0, 4'h0, NO,   1'b1, 32'd0);
    v[6]  = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SF, 2'b00, NO,   NO,   NO,   NO,   1'b1, 32'd1);
    v[7]  = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SD, 2'b00, 4'h8, NO,   NO,   NO,   1'b1, 32'd1);
    v[8]  = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SE, 2'b00, 4'h8, NO,   NO,   NO,   1'b1, 32'd1);
    v[9]  = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SW, 2'b00, 4'h8, NO,   NO,   NO,   1'b1, 32'd1);
    v[10] = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SP, 2'b00, 4'h8, NO,   NO,   NO,   1'b1, 32'd1);
    v[11] = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SF, 2'b00, NO,   NO,   NO,   NO,   1'b1, 32'd2);
    v[12] = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SD, 2'b00, 4'h8, NO,   NO,   NO,   1'b1, 32'd2);
    v[13] = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b1, 1'b0, SE, 2'b00, 4'h8, NO,   NO,   NO,   1'b1, 32'd2);
    v[14] = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SW, 2'b00, 4'h8, NO,   4'h1, NO,   1'b1, 32'd2);
    v[15] = mk(1'b0, 4'h2, 4'h8, 4'h1, 1'b0, 1'b0, SP, 2'b00, 4'h8, NO,   4'h1, NO,   1'b1, 32'd2);
    v[16] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b0, SF, 2'b00, NO,   NO,   NO,   NO,   1'b1, 32'd3);
    v[17] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b0, SD, 2'b00, 4'h4, 4'h4, 4'h4, 4'h1, 1'b1, 32'd3);
    v[18] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b0, SE, 2'b00, 4'h4, 4'h4, 4'h4, 4'h1, 1'b1, 32'd3);
    v[19] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b0, SM, 2'b10, 4'h4, 4'h4, 4'h4, 4'h1, 1'b1, 32'd3);
    v[20] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b0, SM, 2'b10, 4'h4, 4'h4, 4'h4, 4'h1, 1'b1, 32'd3);
    v[21] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b0, SM, 2'b10, 4'h4, 4'h4, 4'h4, 4'h1, 1'b1, 32'd3);
    v[22] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b1, SM, 2'b10, 4'h4, 4'h4, 4'h4, 4'h1, 1'b1, 32'd3);
    v[23] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b0, SW, 2'b00, 4'h4, 4'h4, 4'h4, 4'h1, 1'b1, 32'd3);
    v[24] = mk(1'b0, 4'hB, 4'h1, 4'hF, 1'b0, 1'b0, SP, 2'b00, 4'h4, 4'h4, 4'h4, 4'h1, 1'b1, 32'd3);
    v[25] = mk(1'b0, 4'h6, 4'h0, 4'h1, 1'b0, 1'b0, SF, 2'b00, NO,   NO,   NO,   NO,   1'b1, 32'd4);

    do_reset();
    chk_reset_outputs("reset");

    for (int i = 0; i < 26; i++) begin
      bus.start      = v[i].start;
      bus.icode      = v[i].icode;
      bus.rA         = v[i].ra;
      bus.rB         = v[i].rb;
      bus.Condition  = v[i].cond;
      bus.dmem_ready = v[i].rdy;
      chk($sformatf("row%0d strobes", i), 32'(strobes()), 32'(v[i].strb));
      if (v[i].strb == SM) begin
        chk($sformatf("row%0d rw", i), 32'({bus.mem_read, bus.mem_write}), 32'(v[i].rw));
      end
      chk($sformatf("row%0d srcA", i), 32'(bus.srcA), 32'(v[i].sa));
      chk($sformatf("row%0d srcB", i), 32'(bus.srcB), 32'(v[i].sb));
      chk($sformatf("row%0d dstE", i), 32'(bus.dstE), 32'(v[i].de));
      chk($sformatf("row%0d dstM", i), 32'(bus.dstM), 32'(v[i].dm));
      chk($sformatf("row%0d stat", i), 32'(bus.stat), 32'd0);
      chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(v[i].bz));
      chk($sformatf("row%0d count", i), bus.instr_count, v[i].cnt);
      cyc();
    end

    // addq then halt: two retirements, HLT status, start ignored afterwards
    do_reset();
    start_instr(4'h6, 4'h0, 4'h1);
    repeat (3) cyc();
    chk("halt addq pc_en", 32'(strobes()), 32'(SP));
    cyc();
    bus.icode = 4'h0;
    bus.rA    = 4'hF;
    bus.rB    = 4'hF;
    chk("halt fetch after pc", 32'(strobes()), 32'(SF));
    repeat (4) cyc();
    chk("halt pc_en", 32'(strobes()), 32'(SP));
    cyc();
    chk("halt strobes", 32'(strobes()), 32'(S0));
    chk("halt stat", 32'(bus.stat), 32'd1);
    chk("halt busy", 32'(bus.busy), 32'd0);
    chk("halt count", bus.instr_count, 32'd2);
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("halt ignore start %0d", k), 32'(strobes()), 32'(S0));
    end
    bus.start = 1'b0;

    // rmmovq with dmem_ready stuck low: ADR after exactly 16 MEMORY cycles
    do_reset();
    start_instr(4'h4, 4'h1, 4'h2);
    chk("tmo srcA", 32'(bus.srcA), 32'h1);
    chk("tmo srcB", 32'(bus.srcB), 32'h2);
    cyc();
    cyc();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("tmo mem cycle %0d", k), 32'(strobes()), 32'(SM));
      chk($sformatf("tmo rw %0d", k), 32'({bus.mem_read, bus.mem_write}), 32'b01);
      cyc();
    end
    chk("tmo strobes", 32'(strobes()), 32'(S0));
    chk("tmo stat", 32'(bus.stat), 32'd2);
    chk("tmo busy", 32'(bus.busy), 32'd0);
    chk("tmo count", bus.instr_count, 32'd0);
    repeat (2) cyc();
    chk("tmo stays halted", 32'(strobes()), 32'(S0));

    // mrmovq whose access completes with an error
    do_reset();
    start_instr(4'h5, 4'h3, 4'h2);
    cyc();
    cyc();
    bus.dmem_ready = 1'b1;
    bus.dmem_error = 1'b1;
    chk("derr rw", 32'({bus.mem_read, bus.mem_write}), 32'b10);
    cyc();
    chk("derr strobes", 32'(strobes()), 32'(S0));
    chk("derr stat", 32'(bus.stat), 32'd2);

    // illegal instruction in FETCH
    do_reset();
    bus.start = 1'b1;
    cyc();
    bus.start       = 1'b0;
    bus.instr_valid = 1'b0;
    cyc();
    chk("ins strobes", 32'(strobes()), 32'(S0));
    chk("ins stat", 32'(bus.stat), 32'd3);
    chk("ins busy", 32'(bus.busy), 32'd0);

    // imem_error takes priority over instr_valid
    do_reset();
    bus.start = 1'b1;
    cyc();
    bus.start       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.imem_error  = 1'b1;
    cyc();
    chk("imem prio stat", 32'(bus.stat), 32'd2);

    // reset pulsed during MEMORY of a pushq after one retired addq
    do_reset();
    start_instr(4'h6, 4'h0, 4'h1);
    repeat (4) cyc();
    bus.icode = 4'hA;
    bus.rA    = 4'h3;
    bus.rB    = 4'hF;
    cyc();
    chk("push srcA", 32'(bus.srcA), 32'h3);
    chk("push srcB", 32'(bus.srcB), 32'h4);
    chk("push dstE", 32'(bus.dstE), 32'h4);
    cyc();
    cyc();
    bus.dmem_ready = 1'b0;
    cyc();
    chk("push in memory", 32'(strobes()), 32'(SM));
    chk("push count", bus.instr_count, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async rst");
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk($sformatf("rst held %0d", k), 32'(strobes()), 32'(S0));
    end
    rst_n = 1'b1;
    idle_inputs();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("restart fetch", 32'(strobes()), 32'(SF));
    chk("restart count", bus.instr_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
